// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared types and constants for the core instruction sequencer.
//   state_e        sequencer FSM states
//   B_*            bit positions inside the 34-bit core instruction word
//   inst_fields_t  field-level view of one instruction word
//   IDLE_FIELDS    word that keeps both memories disabled and all strobes low
//   pack_inst()    fields -> 34-bit word
//   imax()         elaboration-time max helper for counter sizing
package core_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_LOAD, S_GAP, S_X_L0, S_FILL, S_EXEC, S_DRAIN, S_ACC, S_DONE
  } state_e;

  localparam int INST_W  = 34;
  localparam int INST_AW = 11;   // address field width in the word

  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  typedef struct packed {
    logic               acc;
    logic               cen_pmem;
    logic               wen_pmem;
    logic [INST_AW-1:0] a_pmem;
    logic               cen_xmem;
    logic               wen_xmem;
    logic [INST_AW-1:0] a_xmem;
    logic               ofifo_rd;
    logic               ififo_wr;
    logic               ififo_rd;
    logic               l0_rd;
    logic               l0_wr;
    logic               execute;
    logic               load;
  } inst_fields_t;

  localparam inst_fields_t IDLE_FIELDS = '{
    acc: 1'b0, cen_pmem: 1'b1, wen_pmem: 1'b1, a_pmem: '0,
    cen_xmem: 1'b1, wen_xmem: 1'b1, a_xmem: '0,
    ofifo_rd: 1'b0, ififo_wr: 1'b0, ififo_rd: 1'b0,
    l0_rd: 1'b0, l0_wr: 1'b0, execute: 1'b0, load: 1'b0
  };

  localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

  function automatic logic [INST_W-1:0] pack_inst(inst_fields_t f);
    logic [INST_W-1:0] w;
    w = '0;
    w[B_ACC]                  = f.acc;
    w[B_CEN_P]                = f.cen_pmem;
    w[B_WEN_P]                = f.wen_pmem;
    w[B_AP_LSB +: INST_AW]    = f.a_pmem;
    w[B_CEN_X]                = f.cen_xmem;
    w[B_WEN_X]                = f.wen_xmem;
    w[B_AX_LSB +: INST_AW]    = f.a_xmem;
    w[B_OFIFO_RD]             = f.ofifo_rd;
    w[B_IFIFO_WR]             = f.ififo_wr;
    w[B_IFIFO_RD]             = f.ififo_rd;
    w[B_L0_RD]                = f.l0_rd;
    w[B_L0_WR]                = f.l0_wr;
    w[B_EXEC]                 = f.execute;
    w[B_LOAD]                 = f.load;
    return w;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core_seq_if.sv
// core_seq_if: host/core-facing signals of the instruction sequencer.
//   master: host side (drives start/mode/abort, forwards ofifo_valid)
//   slave : core_seq side (drives inst, mode_out, busy, done, kij_idx)
interface core_seq_if
  import core_seq_pkg::*;
  ;
  logic              start;
  logic              mode;
  logic              abort;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              mode_out;
  logic              busy;
  logic              done;
  logic [3:0]        kij_idx;

  modport master (output start, mode, abort, ofifo_valid,
                  input  inst, mode_out, busy, done, kij_idx);
  modport slave  (input  start, mode, abort, ofifo_valid,
                  output inst, mode_out, busy, done, kij_idx);
endinterface

// File: rtl/core_seq_phase_cnt.sv
// seq_phase_cnt: loadable down-counter with a terminal flag.
//   load/load_val  synchronous load (wins over en)
//   en             decrement, saturating at zero
//   cnt            current count; last = (cnt == 0)
module seq_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt  = cnt_q;
  assign last = (cnt_q == '0);
endmodule

// File: rtl/core_seq.sv
// core_seq: instruction sequencer for the systolic core. On start it emits
// one 34-bit instruction per cycle for a full conv tile (per-kij weight load,
// PE load, gap, activation load, IFIFO fill, execute, OFIFO drain), then an
// accumulate pass over pmem, then a one-cycle done pulse.
//   clk, reset (async, active low)
//   bus (core_seq_if.slave): start/mode/abort/ofifo_valid in;
//                            inst/mode_out/busy/done/kij_idx out (all registered)
// Optional build macro SEQ_OFIFO_WAIT_EN: DRAIN only reads/writes on cycles
// with ofifo_valid=1 and stalls until LEN_ONIJ words have been moved.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int LEN_KIJ  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int LEN_ONIJ = 16,
  parameter int COL      = 8,
  parameter int ROW      = 8,
  parameter int GAP      = 10,
  parameter int W_BASE   = 1024,
  parameter int AW       = 11
) (
  input logic       clk,
  input logic       reset,
  core_seq_if.slave bus
);
  localparam int EXEC_LEN = LEN_NIJ + COL + ROW + 1;
  localparam int T_MAX = imax(imax(imax(COL, GAP), imax(LEN_NIJ + 1, EXEC_LEN)),
                              imax(LEN_ONIJ, LEN_KIJ + 1));
  localparam int TW = imax(1, $clog2(T_MAX));
  localparam int KW = imax(1, $clog2(LEN_KIJ));
  localparam int OW = imax(1, $clog2(LEN_ONIJ));

  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              busy_q, busy_d, done_q, done_d, mode_q, mode_d;
  logic [3:0]        kij_q, kij_d;

  // t: phase cycle (j sub-step in ACC); k: kernel index; o: ACC output index
  logic          t_load, t_en, t_last;
  logic [TW-1:0] t_val, t_cnt;
  logic          k_load, k_en, k_last;
  logic [KW-1:0] k_val, k_cnt;
  logic          o_load, o_en, o_last;
  logic [OW-1:0] o_val, o_cnt;

  seq_phase_cnt #(.W(TW)) u_t (.clk(clk), .rst_n(reset), .load(t_load), .load_val(t_val),
                               .en(t_en), .cnt(t_cnt), .last(t_last));
  seq_phase_cnt #(.W(KW)) u_k (.clk(clk), .rst_n(reset), .load(k_load), .load_val(k_val),
                               .en(k_en), .cnt(k_cnt), .last(k_last));
  seq_phase_cnt #(.W(OW)) u_o (.clk(clk), .rst_n(reset), .load(o_load), .load_val(o_val),
                               .en(o_en), .cnt(o_cnt), .last(o_last));

  // Counters run down; convert to ascending indices for address math.
  int tc, kij_i, o_i;
  assign tc    = int'(t_cnt);
  assign kij_i = LEN_KIJ - 1 - int'(k_cnt);
  assign o_i   = LEN_ONIJ - 1 - int'(o_cnt);

  logic drain_fire;
`ifdef SEQ_OFIFO_WAIT_EN
  assign drain_fire = bus.ofifo_valid;
`else
  assign drain_fire = 1'b1;
  logic unused_ofifo_valid;
  assign unused_ofifo_valid = bus.ofifo_valid;
`endif

  inst_fields_t f;

  always_comb begin
    state_d = state_q;
    t_load = 1'b0; t_en = 1'b0; t_val = '0;
    k_load = 1'b0; k_en = 1'b0; k_val = '0;
    o_load = 1'b0; o_en = 1'b0; o_val = '0;
    f      = IDLE_FIELDS;
    busy_d = 1'b1;
    done_d = 1'b0;
    mode_d = mode_q;
    kij_d  = 4'(kij_i);

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        kij_d  = '0;
        if (bus.start && !bus.abort) begin
          state_d = S_W_L0;
          mode_d  = bus.mode;
          t_load = 1'b1; t_val = TW'(COL - 1);
          k_load = 1'b1; k_val = KW'(LEN_KIJ - 1);
        end
      end
      S_W_L0: begin
        f.cen_xmem = 1'b0;
        f.l0_wr    = 1'b1;
        f.a_xmem   = INST_AW'(AW'(W_BASE + kij_i * COL + (COL - 1 - tc)));
        if (t_last) begin state_d = S_LOAD; t_load = 1'b1; t_val = TW'(COL - 1); end
        else t_en = 1'b1;
      end
      S_LOAD: begin
        f.load  = 1'b1;
        f.l0_rd = 1'b1;
        if (t_last) begin state_d = S_GAP; t_load = 1'b1; t_val = TW'(GAP - 1); end
        else t_en = 1'b1;
      end
      S_GAP: begin
        if (t_last) begin state_d = S_X_L0; t_load = 1'b1; t_val = TW'(LEN_NIJ - 1); end
        else t_en = 1'b1;
      end
      S_X_L0: begin
        f.cen_xmem = 1'b0;
        f.l0_wr    = 1'b1;
        f.a_xmem   = INST_AW'(AW'(LEN_NIJ - 1 - tc));
        if (t_last) begin state_d = S_FILL; t_load = 1'b1; t_val = TW'(LEN_NIJ); end
        else t_en = 1'b1;
      end
      S_FILL: begin
        f.l0_rd    = 1'b1;
        f.ififo_wr = 1'b1;
        if (t_last) begin state_d = S_EXEC; t_load = 1'b1; t_val = TW'(EXEC_LEN - 1); end
        else t_en = 1'b1;
      end
      S_EXEC: begin
        f.execute  = 1'b1;
        f.ififo_rd = 1'b1;
        if (t_last) begin state_d = S_DRAIN; t_load = 1'b1; t_val = TW'(LEN_ONIJ - 1); end
        else t_en = 1'b1;
      end
      S_DRAIN: begin
        if (drain_fire) begin
          f.ofifo_rd = 1'b1;
          f.cen_pmem = 1'b0;
          f.wen_pmem = 1'b0;
          f.a_pmem   = INST_AW'(AW'(kij_i * LEN_ONIJ + (LEN_ONIJ - 1 - tc)));
          if (t_last) begin
            t_load = 1'b1;
            if (k_last) begin
              // j counts LEN_KIJ..0 so the extra accumulate-only step is last
              state_d = S_ACC;
              t_val   = TW'(LEN_KIJ);
              o_load  = 1'b1; o_val = OW'(LEN_ONIJ - 1);
              k_load  = 1'b1; k_val = KW'(LEN_KIJ - 1);
            end else begin
              state_d = S_W_L0;
              t_val   = TW'(COL - 1);
              k_en    = 1'b1;
            end
          end else t_en = 1'b1;
        end
      end
      S_ACC: begin
        // j = LEN_KIJ - t_cnt; final step (t_cnt==0) only accumulates
        if (!t_last) begin
          f.cen_pmem = 1'b0;
          f.a_pmem   = INST_AW'(AW'((LEN_KIJ - tc) * LEN_ONIJ + o_i));
        end
        f.acc = (tc != LEN_KIJ);
        if (t_last) begin
          if (o_last) state_d = S_DONE;
          else begin
            o_en   = 1'b1;
            t_load = 1'b1; t_val = TW'(LEN_KIJ);
          end
        end else t_en = 1'b1;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        kij_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE: idle word next cycle, no done.
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      f       = IDLE_FIELDS;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      kij_d   = '0;
      t_en = 1'b0; t_load = 1'b1; t_val = '0;
      k_en = 1'b0; k_load = 1'b1; k_val = KW'(LEN_KIJ - 1);
      o_en = 1'b0; o_load = 1'b1; o_val = '0;
    end

    inst_d = pack_inst(f);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      inst_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      kij_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      kij_q   <= kij_d;
    end

  assign bus.inst     = inst_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mode_out = mode_q;
  assign bus.kij_idx  = kij_q;
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: scoreboard bench for core_seq. An independent model pushes the
// expected per-cycle word/busy/done/kij stream when a run is started; each
// cycle the head entry is popped and compared against the DUT.
module tb_core_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_seq_if bus();
  core_seq dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [33:0] inst;
    logic [3:0]  kij;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  localparam int RUN_BUSY = 9 * (8 + 8 + 10 + 36 + 37 + 53 + 16) + 16 * 10;  // 1672

  function automatic logic [33:0] idle_word();
    return {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};
  endfunction

  task automatic push(input logic [33:0] w, input int k, input logic b, input logic d);
    exp_t e;
    e.inst = w; e.kij = 4'(k); e.busy = b; e.done = d;
    q.push_back(e);
  endtask

  task automatic build_run();
    logic [33:0] w;
    for (int k = 0; k < 9; k++) begin
      for (int t = 0; t < 8; t++) begin
        w = idle_word(); w[19] = 1'b0; w[2] = 1'b1; w[17:7] = 11'(1024 + k * 8 + t);
        push(w, k, 1'b1, 1'b0);
      end
      for (int t = 0; t < 8; t++) begin
        w = idle_word(); w[0] = 1'b1; w[3] = 1'b1; push(w, k, 1'b1, 1'b0);
      end
      for (int t = 0; t < 10; t++) push(idle_word(), k, 1'b1, 1'b0);
      for (int t = 0; t < 36; t++) begin
        w = idle_word(); w[19] = 1'b0; w[2] = 1'b1; w[17:7] = 11'(t);
        push(w, k, 1'b1, 1'b0);
      end
      for (int t = 0; t < 37; t++) begin
        w = idle_word(); w[3] = 1'b1; w[5] = 1'b1; push(w, k, 1'b1, 1'b0);
      end
      for (int t = 0; t < 53; t++) begin
        w = idle_word(); w[1] = 1'b1; w[4] = 1'b1; push(w, k, 1'b1, 1'b0);
      end
      for (int t = 0; t < 16; t++) begin
        w = idle_word(); w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(k * 16 + t);
        push(w, k, 1'b1, 1'b0);
      end
    end
    for (int o = 0; o < 16; o++)
      for (int j = 0; j <= 9; j++) begin
        w = idle_word();
        if (j < 9) begin w[32] = 1'b0; w[30:20] = 11'(j * 16 + o); end
        w[33] = (j >= 1);
        push(w, 0, 1'b1, 1'b0);
      end
    push(idle_word(), 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.mode = 1'b0; bus.abort = 1'b0; bus.ofifo_valid = 1'b1;
    reset = 1'b0;
    #12;
    checks++; if (bus.inst !== idle_word()) begin errors++; $display("FAIL reset_inst: got %h want %h", bus.inst, idle_word()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.mode_out !== 1'b0) begin errors++; $display("FAIL reset_mode_out: got %b want 0", bus.mode_out); end
    checks++; if (bus.kij_idx !== 4'd0) begin errors++; $display("FAIL reset_kij: got %0d want 0", bus.kij_idx); end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.inst !== idle_word() || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_hold: inst %h busy %b want %h busy 0", bus.inst, bus.busy, idle_word());
    end
  endtask

  // Full run compared cycle by cycle; optionally pokes start mid-run.
  task automatic test_full_run(input logic m, input bit poke_start);
    exp_t e;
    int busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    q.delete();
    build_run();
    @(negedge clk); bus.start = 1'b1; bus.mode = m;
    @(negedge clk); bus.start = 1'b0; bus.mode = ~m;
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      bus.start = (poke_start && i == 100);
      e = q.pop_front();
      checks++; if (bus.inst !== e.inst) begin errors++; $display("FAIL run_inst[%0d]: got %h want %h", i, bus.inst, e.inst); end
      checks++; if (bus.busy !== e.busy) begin errors++; $display("FAIL run_busy[%0d]: got %b want %b", i, bus.busy, e.busy); end
      checks++; if (bus.done !== e.done) begin errors++; $display("FAIL run_done[%0d]: got %b want %b", i, bus.done, e.done); end
      checks++; if (bus.kij_idx !== e.kij) begin errors++; $display("FAIL run_kij[%0d]: got %0d want %0d", i, bus.kij_idx, e.kij); end
      checks++; if (bus.mode_out !== m) begin errors++; $display("FAIL run_mode_out[%0d]: got %b want %b", i, bus.mode_out, m); end
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
    end
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      done_cnt += int'(bus.done);
      checks++; if (bus.busy !== 1'b0 || bus.inst !== idle_word()) begin
        errors++; $display("FAIL post_run_idle: busy %b inst %h want 0 %h", bus.busy, bus.inst, idle_word());
      end
    end
    checks++; if (busy_cnt != RUN_BUSY) begin errors++; $display("FAIL busy_len: got %0d want %0d", busy_cnt, RUN_BUSY); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_abort_same();
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1; bus.mode = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.inst !== idle_word()) begin
        errors++; $display("FAIL start_abort_same: busy %b inst %h want 0 %h", bus.busy, bus.inst, idle_word());
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    q.delete();
    build_run();
    @(negedge clk); bus.start = 1'b1; bus.mode = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++; if (bus.inst !== e.inst || bus.busy !== e.busy) begin
        errors++; $display("FAIL pre_abort[%0d]: inst %h busy %b want %h %b", i, bus.inst, bus.busy, e.inst, e.busy);
      end
    end
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    checks++; if (bus.inst !== idle_word()) begin errors++; $display("FAIL abort_inst: got %h want %h", bus.inst, idle_word()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    checks++; if (bus.kij_idx !== 4'd0) begin errors++; $display("FAIL abort_kij: got %0d want 0", bus.kij_idx); end
    repeat (5) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.inst !== idle_word()) begin
        errors++; $display("FAIL abort_quiet: done %b busy %b inst %h want 0 0 %h", bus.done, bus.busy, bus.inst, idle_word());
      end
    end
    q.delete();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); bus.start = 1'b1; bus.mode = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_run_busy: got %b want 1", bus.busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.inst !== idle_word()) begin errors++; $display("FAIL rst_mid_inst: got %h want %h", bus.inst, idle_word()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.mode_out !== 1'b0) begin errors++; $display("FAIL rst_mid_mode: got %b want 0", bus.mode_out); end
    checks++; if (bus.kij_idx !== 4'd0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_kij_done: kij %0d done %b want 0 0", bus.kij_idx, bus.done);
    end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.inst !== idle_word()) begin
      errors++; $display("FAIL rst_mid_after: busy %b inst %h", bus.busy, bus.inst);
    end
  endtask

`ifdef SEQ_OFIFO_WAIT_EN
  // ofifo_valid low for state cycles 152..156 (first five kij0 DRAIN cycles).
  task automatic test_ofifo_wait();
    int writes, w1_start;
    writes = 0; w1_start = -1;
    @(negedge clk); bus.start = 1'b1; bus.mode = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.ofifo_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.ofifo_valid = !((i + 1) >= 152 && (i + 1) <= 156);
      if (bus.inst[6] && !bus.inst[31] && !bus.inst[32]) writes++;
      if (w1_start < 0 && bus.inst[2] && !bus.inst[19] && bus.inst[17:7] == 11'd1032) w1_start = i;
    end
    bus.ofifo_valid = 1'b1;
    checks++; if (writes != 16) begin errors++; $display("FAIL wait_writes: got %0d want 16", writes); end
    checks++; if (w1_start - 152 != 21) begin errors++; $display("FAIL wait_drain_len: got %0d want 21", w1_start - 152); end
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wait_abort_busy: got %b want 0", bus.busy); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_run(1'b1, 1'b1);
    test_start_abort_same();
    test_abort();
    test_full_run(1'b0, 1'b0);
    test_reset_mid_run();
`ifdef SEQ_OFIFO_WAIT_EN
    test_ofifo_wait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
